// File: rtl/pixel_window_3x3_if.sv
// Stream bundle between the raster pixel source, the 3x3 window builder and the blur stage.
// With WINDOW_COORD_EN defined the bundle also carries the centre coordinates of each window.
interface pixel_window_3x3_if #(
    parameter int unsigned DATA_W = 8
) ();
    logic [DATA_W-1:0]   in_pixel;
    logic                in_valid;
    logic                in_ready;
    logic [9*DATA_W-1:0] win;
    logic                win_valid;
    logic                win_ready;
`ifdef WINDOW_COORD_EN
    logic [15:0]         win_row;
    logic [15:0]         win_col;

    modport master (
        output in_pixel, in_valid, win_ready,
        input  in_ready, win, win_valid, win_row, win_col
    );
    modport slave (
        input  in_pixel, in_valid, win_ready,
        output in_ready, win, win_valid, win_row, win_col
    );
`else
    modport master (
        output in_pixel, in_valid, win_ready,
        input  in_ready, win, win_valid
    );
    modport slave (
        input  in_pixel, in_valid, win_ready,
        output in_ready, win, win_valid
    );
`endif
endinterface

// File: rtl/pixel_window_3x3.sv
// Raster stream to 3x3 neighbourhood converter feeding the blur stage; interior pixels only.
// Optional WINDOW_COORD_EN adds registered centre coordinates alongside each window.
module pixel_window_3x3 #(
    parameter int unsigned WIDTH  = 20,
    parameter int unsigned HEIGHT = 20,
    parameter int unsigned DATA_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                done,
    pixel_window_3x3_if.slave   bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
    typedef logic [8:0][DATA_W-1:0] window_t;

    state_e            state_q, state_d;
    logic [15:0]       row_q, row_d, col_q, col_d;
    window_t           sw_q, sw_d, win_q, win_d;
    logic              win_valid_q, win_valid_d;
    logic              done_q, done_d;
`ifdef WINDOW_COORD_EN
    logic [15:0]       win_row_q, win_row_d, win_col_q, win_col_d;
`endif

    logic [DATA_W-1:0] lb0_q [WIDTH];
    logic [DATA_W-1:0] lb1_q [WIDTH];

    logic              in_ready_c, accept_c;
    logic [CW-1:0]     lb_idx_c;
    logic [DATA_W-1:0] top_c, mid_c;

    assign lb_idx_c   = col_q[CW-1:0];
    assign top_c      = lb1_q[lb_idx_c];
    assign mid_c      = lb0_q[lb_idx_c];
    assign in_ready_c = (state_q == RUN) && (!win_valid_q || bus.win_ready);
    assign accept_c   = bus.in_valid && in_ready_c;

    // Next-state, counters, shift window and output window load
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        sw_d        = sw_q;
        win_d       = win_q;
        win_valid_d = win_valid_q;
        done_d      = 1'b0;
`ifdef WINDOW_COORD_EN
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;
`endif
        if (win_valid_q && bus.win_ready) begin
            win_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            RUN: begin
                if (accept_c) begin
                    sw_d[0] = sw_q[1];
                    sw_d[1] = sw_q[2];
                    sw_d[2] = top_c;
                    sw_d[3] = sw_q[4];
                    sw_d[4] = sw_q[5];
                    sw_d[5] = mid_c;
                    sw_d[6] = sw_q[7];
                    sw_d[7] = sw_q[8];
                    sw_d[8] = bus.in_pixel;
                    if (row_q >= 16'd2 && col_q >= 16'd2) begin
                        win_d       = sw_d;
                        win_valid_d = 1'b1;
`ifdef WINDOW_COORD_EN
                        win_row_d   = row_q - 16'd1;
                        win_col_d   = col_q - 16'd1;
`endif
                    end
                    if (col_q == 16'(WIDTH - 1)) begin
                        col_d = '0;
                        if (row_q == 16'(HEIGHT - 1)) begin
                            row_d   = '0;
                            state_d = DRAIN;
                        end else begin
                            row_d = row_q + 16'd1;
                        end
                    end else begin
                        col_d = col_q + 16'd1;
                    end
                end
            end
            DRAIN: begin
                // Frame ends only once the final window has been taken
                if (!win_valid_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            sw_q        <= '0;
            win_q       <= '0;
            win_valid_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef WINDOW_COORD_EN
            win_row_q   <= '0;
            win_col_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            sw_q        <= sw_d;
            win_q       <= win_d;
            win_valid_q <= win_valid_d;
            done_q      <= done_d;
`ifdef WINDOW_COORD_EN
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
`endif
        end
    end

    // Line buffers need no reset: rows 0 and 1 refill them before any window uses them
    always_ff @(posedge clk) begin
        if (accept_c) begin
            lb1_q[lb_idx_c] <= mid_c;
            lb0_q[lb_idx_c] <= bus.in_pixel;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.win       = win_q;
    assign bus.win_valid = win_valid_q;
    assign done          = done_q;
`ifdef WINDOW_COORD_EN
    assign bus.win_row   = win_row_q;
    assign bus.win_col   = win_col_q;
`endif
endmodule
